// File: rtl/dfi_cmd_sequencer.sv
// dfi_cmd_sequencer: DDR command-side controller for a 1:2 DFI PHY.
// Runs power-up init, periodic auto-refresh and single host commands
// (req/ack) on command slot p0; slot p1 always carries NOP.
// Optional build macro: DFI_SEQ_DLL_RESET_EN (MRS with DLL reset, then a
// second MRS without it after the second init refresh).
module dfi_cmd_sequencer #(
    parameter int unsigned NUM_AD    = 13,
    parameter int unsigned NUM_BA    = 2,
    parameter int unsigned INIT_WAIT = 20000,
    parameter int unsigned TRP       = 2,
    parameter int unsigned TRFC      = 8,
    parameter int unsigned TMRD      = 2,
    parameter int unsigned TREFI     = 780,
    parameter logic [NUM_AD-1:0] MR_VALUE  = 13'h0022,
    parameter logic [NUM_AD-1:0] EMR_VALUE = 13'h0000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              host_req,
    input  logic              host_ras_n,
    input  logic              host_cas_n,
    input  logic              host_we_n,
    input  logic [NUM_AD-1:0] host_address,
    input  logic [NUM_BA-1:0] host_bank,
    output logic              host_ack,
    output logic              dfi_cs_n_p0,
    output logic              dfi_cs_n_p1,
    output logic              dfi_cke_p0,
    output logic              dfi_cke_p1,
    output logic              dfi_ras_n_p0,
    output logic              dfi_ras_n_p1,
    output logic              dfi_cas_n_p0,
    output logic              dfi_cas_n_p1,
    output logic              dfi_we_n_p0,
    output logic              dfi_we_n_p1,
    output logic [NUM_AD-1:0] dfi_address_p0,
    output logic [NUM_AD-1:0] dfi_address_p1,
    output logic [NUM_BA-1:0] dfi_bank_p0,
    output logic [NUM_BA-1:0] dfi_bank_p1,
    output logic              init_done,
    output logic              refresh_busy
);

    localparam int unsigned WAIT_A   = (INIT_WAIT > TRP) ? INIT_WAIT : TRP;
    localparam int unsigned WAIT_B   = (TRFC > TMRD) ? TRFC : TMRD;
    localparam int unsigned WAIT_MAX = (WAIT_A > WAIT_B) ? WAIT_A : WAIT_B;
    localparam int unsigned CW       = $clog2(WAIT_MAX + 1);
    localparam int unsigned TW       = $clog2(TREFI + 1);

`ifdef DFI_SEQ_DLL_RESET_EN
    localparam logic [NUM_AD-1:0] MR_FIRST = MR_VALUE | (NUM_AD'(1) << 8);
`else
    localparam logic [NUM_AD-1:0] MR_FIRST = MR_VALUE;
`endif

    typedef enum logic [4:0] {
        ST_RST_WAIT, ST_CKE_UP, ST_PREA, ST_WAIT_RP, ST_EMRS, ST_WAIT_EMR,
        ST_MRS, ST_WAIT_MR, ST_REF1, ST_WAIT_RF1, ST_REF2, ST_WAIT_RF2,
        ST_MRS2, ST_WAIT_MR2, ST_IDLE, ST_REF, ST_WAIT_REF, ST_HOST
    } state_t;

    state_t            state, state_next, arb;
    logic [CW-1:0]     cnt, cnt_next;
    logic [TW-1:0]     tmr, tmr_next;
    logic              timer_run, timer_run_next;
    logic              pending, pending_next;
    logic              expire, wait_done;
    int unsigned       lim;
    logic              cke_n;
    logic [3:0]        cmd_n;
    logic [NUM_AD-1:0] addr_n;
    logic [NUM_BA-1:0] bank_n;

    // Next-state, counters, refresh timer and next output values.
    // Outputs are registered from the next state so each state's command
    // appears on p0 during exactly the cycle the FSM occupies that state.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        expire     = timer_run && (tmr == TW'(TREFI - 1));
        arb        = (pending || expire) ? ST_REF : (host_req ? ST_HOST : ST_IDLE);
        case (state)
            ST_RST_WAIT:                          lim = INIT_WAIT;
            ST_WAIT_RP:                           lim = TRP;
            ST_WAIT_EMR, ST_WAIT_MR, ST_WAIT_MR2: lim = TMRD;
            ST_WAIT_RF1, ST_WAIT_RF2, ST_WAIT_REF: lim = TRFC;
            default:                              lim = 1;
        endcase
        wait_done = (cnt == CW'(lim - 1));

        case (state)
            ST_RST_WAIT: if (wait_done) state_next = ST_CKE_UP; else cnt_next = cnt + CW'(1);
            ST_CKE_UP:   state_next = ST_PREA;
            ST_PREA:     state_next = ST_WAIT_RP;
            ST_WAIT_RP:  if (wait_done) state_next = ST_EMRS; else cnt_next = cnt + CW'(1);
            ST_EMRS:     state_next = ST_WAIT_EMR;
            ST_WAIT_EMR: if (wait_done) state_next = ST_MRS; else cnt_next = cnt + CW'(1);
            ST_MRS:      state_next = ST_WAIT_MR;
            ST_WAIT_MR:  if (wait_done) state_next = ST_REF1; else cnt_next = cnt + CW'(1);
            ST_REF1:     state_next = ST_WAIT_RF1;
            ST_WAIT_RF1: if (wait_done) state_next = ST_REF2; else cnt_next = cnt + CW'(1);
            ST_REF2:     state_next = ST_WAIT_RF2;
`ifdef DFI_SEQ_DLL_RESET_EN
            ST_WAIT_RF2: if (wait_done) state_next = ST_MRS2; else cnt_next = cnt + CW'(1);
            ST_MRS2:     state_next = ST_WAIT_MR2;
            ST_WAIT_MR2: if (wait_done) state_next = ST_IDLE; else cnt_next = cnt + CW'(1);
`else
            ST_WAIT_RF2: if (wait_done) state_next = ST_IDLE; else cnt_next = cnt + CW'(1);
`endif
            ST_IDLE:     state_next = arb;
            ST_REF:      state_next = ST_WAIT_REF;
            // Arbitrating in the last wait cycle lets the next command land
            // exactly TRFC+1 cycles after the refresh.
            ST_WAIT_REF: if (wait_done) state_next = arb; else cnt_next = cnt + CW'(1);
            ST_HOST:     state_next = ST_IDLE;
            default:     state_next = ST_RST_WAIT;
        endcase

        // An expiry taken straight into ST_REF never shows up as pending.
        pending_next   = (state_next == ST_REF) ? 1'b0 : (pending || expire);
        timer_run_next = timer_run || (state_next == ST_IDLE);
        tmr_next       = (!timer_run || expire) ? '0 : tmr + TW'(1);

        cke_n  = (state_next != ST_RST_WAIT);
        cmd_n  = 4'b1111;
        addr_n = '0;
        bank_n = '0;
        case (state_next)
            ST_PREA: begin cmd_n = 4'b0010; addr_n[10] = 1'b1; end
            ST_EMRS: begin cmd_n = 4'b0000; bank_n = NUM_BA'(1); addr_n = EMR_VALUE; end
            ST_MRS:  begin cmd_n = 4'b0000; addr_n = MR_FIRST; end
            ST_MRS2: begin cmd_n = 4'b0000; addr_n = MR_VALUE; end
            ST_REF1, ST_REF2, ST_REF: cmd_n = 4'b0001;
            ST_HOST: begin
                cmd_n  = {1'b0, host_ras_n, host_cas_n, host_we_n};
                addr_n = host_address;
                bank_n = host_bank;
            end
            default: ;
        endcase
    end

    // FSM state, wait counter and refresh timer registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_RST_WAIT;
            cnt       <= '0;
            tmr       <= '0;
            timer_run <= 1'b0;
            pending   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            tmr       <= tmr_next;
            timer_run <= timer_run_next;
            pending   <= pending_next;
        end
    end

    // Registered DFI command slots and status outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dfi_cke_p0     <= 1'b0;
            dfi_cke_p1     <= 1'b0;
            {dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0} <= 4'b1111;
            {dfi_cs_n_p1, dfi_ras_n_p1, dfi_cas_n_p1, dfi_we_n_p1} <= 4'b1111;
            dfi_address_p0 <= '0;
            dfi_address_p1 <= '0;
            dfi_bank_p0    <= '0;
            dfi_bank_p1    <= '0;
            host_ack       <= 1'b0;
            init_done      <= 1'b0;
            refresh_busy   <= 1'b0;
        end else begin
            dfi_cke_p0     <= cke_n;
            dfi_cke_p1     <= cke_n;
            {dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0} <= cmd_n;
            {dfi_cs_n_p1, dfi_ras_n_p1, dfi_cas_n_p1, dfi_we_n_p1} <= 4'b1111;
            dfi_address_p0 <= addr_n;
            dfi_address_p1 <= '0;
            dfi_bank_p0    <= bank_n;
            dfi_bank_p1    <= '0;
            host_ack       <= (state_next == ST_HOST);
            init_done      <= init_done || (state_next == ST_IDLE);
            refresh_busy   <= pending_next ||
                              (state_next inside {ST_REF1, ST_WAIT_RF1, ST_REF2,
                                                  ST_WAIT_RF2, ST_REF, ST_WAIT_REF});
        end
    end

endmodule

// File: tb/tb_dfi_cmd_sequencer.sv
// Self-checking bench for dfi_cmd_sequencer: init timeline, refresh cadence,
// random host traffic and mid-init reset, against a schedule-level model.
module tb_dfi_cmd_sequencer;
    localparam int IW = 10, RP = 2, MRD = 2, RFC = 8, REFI = 50;
    localparam logic [12:0] MRV  = 13'h0022;
    localparam logic [12:0] EMRV = 13'h0000;
    localparam int T_PREA = IW + 1;
    localparam int T_EMRS = T_PREA + RP + 1;
    localparam int T_MRS  = T_EMRS + MRD + 1;
    localparam int T_REF1 = T_MRS + MRD + 1;
    localparam int T_REF2 = T_REF1 + RFC + 1;
`ifdef DFI_SEQ_DLL_RESET_EN
    localparam int T_MRS2 = T_REF2 + RFC + 1;
    localparam int T_IDLE = T_MRS2 + MRD + 1;
    localparam logic [12:0] MR_FIRST = MRV | 13'h0100;
`else
    localparam int T_MRS2 = -1;
    localparam int T_IDLE = T_REF2 + RFC + 1;
    localparam logic [12:0] MR_FIRST = MRV;
`endif
    // command kinds used by the model
    localparam int K_NOP = 0, K_PREA = 1, K_EMRS = 2, K_MRS = 3, K_MRS2 = 4, K_REF = 5, K_HOST = 6;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        host_req = 1'b0, host_ras_n = 1'b1, host_cas_n = 1'b1, host_we_n = 1'b1;
    logic [12:0] host_address = '0;
    logic [1:0]  host_bank = '0;
    logic        host_ack, init_done, refresh_busy;
    logic        cs0, cs1, cke0, cke1, ras0, ras1, cas0, cas1, we0, we1;
    logic [12:0] addr0, addr1;
    logic [1:0]  ba0, ba1;

    int checks = 0, errors = 0, cyc = 0, kind = 0;
    int earliest, next_due, last_ref;
    bit due;

    dfi_cmd_sequencer #(.NUM_AD(13), .NUM_BA(2), .INIT_WAIT(IW), .TRP(RP), .TRFC(RFC),
                        .TMRD(MRD), .TREFI(REFI), .MR_VALUE(MRV), .EMR_VALUE(EMRV)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .host_req(host_req), .host_ras_n(host_ras_n),
        .host_cas_n(host_cas_n), .host_we_n(host_we_n), .host_address(host_address),
        .host_bank(host_bank), .host_ack(host_ack),
        .dfi_cs_n_p0(cs0), .dfi_cs_n_p1(cs1), .dfi_cke_p0(cke0), .dfi_cke_p1(cke1),
        .dfi_ras_n_p0(ras0), .dfi_ras_n_p1(ras1), .dfi_cas_n_p0(cas0), .dfi_cas_n_p1(cas1),
        .dfi_we_n_p0(we0), .dfi_we_n_p1(we1), .dfi_address_p0(addr0), .dfi_address_p1(addr1),
        .dfi_bank_p0(ba0), .dfi_bank_p1(ba1), .init_done(init_done), .refresh_busy(refresh_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " cke"}, 32'({cke0, cke1}), 32'd0);
        chk({tag, " cmd_p0"}, 32'({cs0, ras0, cas0, we0}), 32'hF);
        chk({tag, " cmd_p1"}, 32'({cs1, ras1, cas1, we1}), 32'hF);
        chk({tag, " addr_bank"}, 32'({addr0, ba0}), 32'd0);
        chk({tag, " status"}, 32'({host_ack, init_done, refresh_busy}), 32'd0);
    endtask

    task automatic model_init();
        earliest = T_IDLE + 1;
        next_due = T_IDLE + REFI;
        last_ref = -1000;
        due      = 1'b0;
    endtask

    // Schedule model: fixed init timeline, then REF due every REFI cycles from
    // IDLE entry; a due refresh beats a waiting host; host commands need one
    // NOP after them, refreshes need RFC cycles after them.
    task automatic cycle_check();
        logic [3:0] exp_cmd;
        bit         busy;
        kind = K_NOP;
        if (cyc == T_PREA) kind = K_PREA;
        else if (cyc == T_EMRS) kind = K_EMRS;
        else if (cyc == T_MRS) kind = K_MRS;
        else if (cyc == T_REF1 || cyc == T_REF2) kind = K_REF;
        else if (cyc == T_MRS2) kind = K_MRS2;
        else if (cyc > T_IDLE) begin
            if (cyc == next_due) begin due = 1'b1; next_due += REFI; end
            if (cyc >= earliest && due) begin
                kind = K_REF; due = 1'b0; earliest = cyc + RFC + 1; last_ref = cyc;
            end else if (cyc >= earliest && host_req) begin
                kind = K_HOST; earliest = cyc + 2;
            end
        end
        case (kind)
            K_PREA:                exp_cmd = 4'b0010;
            K_EMRS, K_MRS, K_MRS2: exp_cmd = 4'b0000;
            K_REF:                 exp_cmd = 4'b0001;
            K_HOST:                exp_cmd = {1'b0, host_ras_n, host_cas_n, host_we_n};
            default:               exp_cmd = 4'b1111;
        endcase
        busy = due || (cyc >= last_ref && cyc <= last_ref + RFC) ||
               (cyc >= T_REF1 && cyc <= T_REF1 + RFC) || (cyc >= T_REF2 && cyc <= T_REF2 + RFC);

        chk("cke_p0", 32'(cke0), 32'(cyc >= IW));
        chk("cke_p1", 32'(cke1), 32'(cyc >= IW));
        chk("cmd_p0", 32'({cs0, ras0, cas0, we0}), 32'(exp_cmd));
        chk("cmd_p1", 32'({cs1, ras1, cas1, we1}), 32'hF);
        chk("host_ack", 32'(host_ack), 32'(kind == K_HOST));
        chk("init_done", 32'(init_done), 32'(cyc >= T_IDLE));
        chk("refresh_busy", 32'(refresh_busy), 32'(busy));
        case (kind)
            K_PREA: chk("prea_a10", 32'(addr0[10]), 32'd1);
            K_EMRS: chk("emrs_ba_addr", 32'({ba0, addr0}), 32'({2'd1, EMRV}));
            K_MRS:  chk("mrs_ba_addr", 32'({ba0, addr0}), 32'({2'd0, MR_FIRST}));
            K_MRS2: chk("mrs2_ba_addr", 32'({ba0, addr0}), 32'({2'd0, MRV}));
            K_HOST: chk("host_ba_addr", 32'({ba0, addr0}), 32'({host_bank, host_address}));
            default: ;
        endcase
    endtask

    task automatic start_req();
        host_req     = 1'b1;
        host_ras_n   = 1'($urandom_range(0, 1));
        host_cas_n   = 1'($urandom_range(0, 1));
        host_we_n    = 1'($urandom_range(0, 1));
        host_address = 13'($urandom);
        host_bank    = 2'($urandom);
    endtask

    task automatic step(input bit rand_en);
        cycle_check();
        if (kind == K_HOST) host_req = 1'b0;
        // Force some requests onto the refresh expiry cycle.
        if (rand_en && !host_req && ((cyc + 1 == next_due) || $urandom_range(0, 2) == 0))
            start_req();
        @(negedge clk);
        cyc++;
    endtask

    task automatic hold_act();
        host_req = 1'b1; host_ras_n = 1'b0; host_cas_n = 1'b1; host_we_n = 1'b1;
        host_address = 13'h155; host_bank = 2'd2;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset("reset");

        // Run 1: host request held during init, reset pulsed in REF1 wait.
        hold_act();
        model_init();
        rst_n = 1'b1; cyc = 0;
        for (int i = 0; i <= T_REF1 + 3; i++) step(1'b0);
        rst_n = 1'b0;
        #1;
        check_reset("mid_reset");
        repeat (2) @(negedge clk);
        check_reset("held_reset");

        // Run 2: full init, random traffic, then an idle bus.
        hold_act();
        model_init();
        rst_n = 1'b1; cyc = 0;
        for (int i = 0; i < T_IDLE + 250; i++) step(1'b1);
        for (int i = 0; i < 300; i++) step(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
